// File: rtl/timer_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_display_scan_if
// Description : Bundle between the timer core (packed BCD time plus edit and
//               expiry status) and the multiplexed seven-segment display pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_display_scan_if;
  logic [35:0] time_i;
  logic [2:0]  curr_digit;
  logic        edit;
  logic        done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  // Timer side: supplies time and status, observes the display pins
  modport master (
    output time_i, curr_digit, edit, done,
    input  an, seg, dp
  );

  // Display scanner side
  modport slave (
    input  time_i, curr_digit, edit, done,
    output an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/timer_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : timer_display_scan
// Description : Scans an 8-digit active-low seven-segment display from the
//               timer's packed BCD word. Input data is captured once per
//               frame so a frame never mixes old and new digits. Decimal
//               points give HH.MM.SS.cc; the edited digit or the whole
//               display blinks.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  timer_display_scan_if.slave bus
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0] refresh_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;
  logic [2:0]       scan_idx;
  logic             slot_tick;
  logic             blink_tick;

  logic [35:0]      time_s;
  logic             edit_s;
  logic [2:0]       curr_digit_s;
  logic             done_s;

  logic [5:0]       nib_base;
  logic [3:0]       digit_nib;
  logic [6:0]       seg_next;
  logic [7:0]       an_next;
  logic             dp_next;
  logic             blank_slot;

  logic [7:0]       an_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;

  assign slot_tick  = (refresh_cnt == REF_LAST);
  assign blink_tick = (blink_cnt == BLK_LAST);

  // Slot timer: wraps on its terminal count, which is the slot tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         refresh_cnt <= '0;
    else if (slot_tick) refresh_cnt <= '0;
    else                refresh_cnt <= refresh_cnt + 1'b1;
  end

  // Scan index advances one digit per slot and wraps 7 -> 0 naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         scan_idx <= 3'd0;
    else if (slot_tick) scan_idx <= scan_idx + 3'd1;
  end

  // Frame latch: capture timer state only when the scan wraps to digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_s       <= '0;
      edit_s       <= 1'b0;
      curr_digit_s <= 3'd0;
      done_s       <= 1'b0;
    end else if (slot_tick && (scan_idx == 3'd7)) begin
      time_s       <= bus.time_i;
      edit_s       <= bus.edit;
      curr_digit_s <= bus.curr_digit;
      done_s       <= bus.done;
    end
  end

  // Free-running blink phase; starts in the ON phase after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_tick) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Digit select, seven-segment decode, blanking and decimal point
  always_comb begin
    // Index i shows nibble [4i+7:4i+4]; the lowest nibble is never shown
    nib_base  = {1'b0, scan_idx, 2'b00} + 6'd4;
    digit_nib = time_s[nib_base +: 4];

    unique case (digit_nib)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase

    // Edit mode takes priority over expiry; digits 6/7 under edit never blink
    blank_slot = 1'b0;
    if (!blink_on) begin
      if (edit_s)
        blank_slot = (curr_digit_s <= 3'd5) && (scan_idx == (3'd7 - curr_digit_s));
      else
        blank_slot = done_s;
    end

    an_next = blank_slot ? 8'hFF : ~(8'b0000_0001 << scan_idx);
    dp_next = !((scan_idx == 3'd2) || (scan_idx == 3'd4) || (scan_idx == 3'd6));
  end

  // Registered pin drivers, one clk behind the scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign bus.an  = an_reg;
  assign bus.seg = seg_reg;
  assign bus.dp  = dp_reg;

endmodule
`default_nettype wire

// File: tb/tb_timer_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_display_scan
// Description : Scoreboard bench for the display scanner with REFRESH_DIV=4
//               and BLINK_DIV=64 (one blink half-period = two frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_display_scan;

  localparam int NFRAMES = 16;

  typedef struct packed {
    logic [35:0] t;
    logic        e;
    logic [2:0]  cd;
    logic        d;
  } frame_cfg_t;

  typedef struct packed {
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   mon_en = 1'b0;
  bit   mon_en_q;
  int   total = 0;
  int   bad = 0;

  frame_cfg_t cfg [NFRAMES];
  exp_t       sb_q [$];

  timer_display_scan_if bus ();

  timer_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Hand table of active-low {g,f,e,d,c,b,a} patterns
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Queue the 32 per-cycle expectations of frame f (8 slots x 4 cycles)
  task automatic push_frame(input int f);
    frame_cfg_t c;
    exp_t       x;
    bit         off;
    bit         blank;
    logic [3:0] nib;
    c   = cfg[f];
    off = ((f / 2) % 2) == 1;
    for (int k = 0; k < 8; k++) begin
      nib = c.t[4*k+4 +: 4];
      if (c.e) blank = off && (c.cd <= 3'd5) && (k == 7 - int'(c.cd));
      else     blank = off && c.d;
      x.an  = blank ? 8'hFF : ~(8'b0000_0001 << k);
      x.seg = seg_of(nib);
      x.dp  = !((k == 2) || (k == 4) || (k == 6));
      x.tag = 16'(f * 8 + k);
      for (int r = 0; r < 4; r++) sb_q.push_back(x);
    end
  endtask

  task automatic apply_cfg(input int f);
    bus.time_i     = cfg[f].t;
    bus.edit       = cfg[f].e;
    bus.curr_digit = cfg[f].cd;
    bus.done       = cfg[f].d;
  endtask

  // Monitor: the display presents a new output every clk; compare each one
  always begin
    exp_t x;
    @(posedge clk);
    mon_en_q = mon_en;
    #3;
    if (mon_en_q) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: got an=%h with no expectation queued", bus.an);
      end else begin
        x = sb_q.pop_front();
        if (bus.an !== x.an || bus.seg !== x.seg || bus.dp !== x.dp) begin
          bad++;
          $display("FAIL scan f%0d s%0d: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                   x.tag / 8, x.tag % 8, bus.an, bus.seg, bus.dp, x.an, x.seg, x.dp);
        end
      end
    end
  end

  initial begin
    // Frames show data latched at the end of the previous frame
    cfg[0]  = '{36'h000000000, 1'b0, 3'd0, 1'b0};
    cfg[1]  = '{36'h123456789, 1'b0, 3'd0, 1'b0};
    cfg[2]  = '{36'h000000000, 1'b0, 3'd0, 1'b0};
    cfg[3]  = '{36'h123456789, 1'b1, 3'd2, 1'b0};
    cfg[4]  = '{36'h123456789, 1'b1, 3'd2, 1'b0};
    cfg[5]  = '{36'h123456789, 1'b1, 3'd6, 1'b0};
    cfg[6]  = '{36'h123456789, 1'b1, 3'd6, 1'b0};
    cfg[7]  = '{36'h123456789, 1'b0, 3'd0, 1'b1};
    cfg[8]  = '{36'h123456789, 1'b0, 3'd0, 1'b1};
    cfg[9]  = '{36'h123456789, 1'b0, 3'd0, 1'b1};
    cfg[10] = '{36'h123456789, 1'b0, 3'd0, 1'b1};
    cfg[11] = '{36'h123456789, 1'b0, 3'd0, 1'b1};
    cfg[12] = '{36'h123456789, 1'b1, 3'd0, 1'b1};
    cfg[13] = '{36'h123456789, 1'b1, 3'd0, 1'b1};
    cfg[14] = '{36'h123456789, 1'b1, 3'd0, 1'b1};
    cfg[15] = '{36'h1234A6789, 1'b0, 3'd0, 1'b0};

    rst_n = 1'b0;
    apply_cfg(0);

    // Reset values while held
    repeat (3) @(posedge clk);
    #1;
    check("reset_an",  bus.an,         8'hFF);
    check("reset_seg", {1'b0, bus.seg}, 8'h7F);
    check("reset_dp",  {7'd0, bus.dp},  8'h01);

    // Release: slot 1 appears on the fifth edge
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("scan_slot1_an",  bus.an,          8'hFD);
    check("scan_slot1_seg", {1'b0, bus.seg}, 8'h40);
    check("scan_slot1_dp",  {7'd0, bus.dp},  8'h01);

    // Asynchronous reset mid-slot, no clock edge in between
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an",  bus.an,          8'hFF);
    check("async_rst_seg", {1'b0, bus.seg}, 8'h7F);
    check("async_rst_dp",  {7'd0, bus.dp},  8'h01);

    // Scoreboarded run: inputs for frame f+1 change at index 3 of frame f
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int f = 0; f < NFRAMES; f++) begin
      push_frame(f);
      repeat (12) @(posedge clk);
      #1;
      if (f + 1 < NFRAMES) apply_cfg(f + 1);
      repeat (20) @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_display_scan.md
Name: timer_display_scan

Overview:
- Reader side of the countdown timer's packed BCD output; drives the board's 8-digit multiplexed seven-segment display.
- Samples the 36-bit time word and the edit/done status once per scan frame, so digits never tear mid-frame.
- Scans the eight digits, shows decimal points as HH.MM.SS.cc, and blinks the digit under edit or the whole display on expiry.
- Sits between the timer core and the top-level display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥1.
- BLINK_DIV, 25000000: clk cycles per blink half-period (2 Hz blink at 100 MHz); legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- time_i  input  36  packed BCD, nibbles [35:32]..[3:0] = h2,h1,m2,m1,s2,s1,ms3,ms2,ms1
- curr_digit  input  3  digit being edited: 0=h2 .. 5=s1
- edit  input  1  timer in edit mode
- done  input  1  countdown expired
- an  output  8  digit anodes, active-low; an[7] = leftmost digit
- seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low

Behaviour:
- Reset (asynchronous, immediate): an=8'hFF, seg=7'h7F, dp=1, scan index=0, refresh and blink counters=0, blink phase=ON, shadow registers (time, edit, curr_digit, done)=0.
- Refresh counter counts 0..REFRESH_DIV-1. The terminal count is the slot tick; the counter wraps to 0 on it. With REFRESH_DIV=1 the tick fires every cycle.
- Scan index 0..7 advances on each slot tick and wraps 7->0.
- Frame latch: on the slot tick where index==7 (wrap to 0), capture time_i, edit, curr_digit and done into the shadow registers. The displayed data changes only at frame start.
- Digit mapping: index i displays shadow nibble [4i+7:4i+4].
  - Index 7=h2, 6=h1, 5=m2, 4=m1, 3=s2, 2=s1, 1=ms3, 0=ms2.
  - ms1 ([3:0]) is not displayed.
- Decimal point: dp=0 at indices 6, 4, 2; dp=1 elsewhere.
- Segment decode, standard active-low table. Examples:
  - 0 -> 7'b1000000
  - 1 -> 7'b1111001
  - 8 -> 7'b0000000
  - 9 -> 7'b0010000
  - Nibble values A..F show a dash, 7'b0111111.
- Blink: the blink counter counts 0..BLINK_DIV-1 and toggles the phase on the terminal count. It free-runs and is reset only by rst_n.
- Blanking (evaluated on shadow values, while phase=OFF):
  - If edit_s=1 and curr_digit_s<=5 and index==7-curr_digit_s: that slot's anode is held high (digit dark) and all other slots display normally.
  - If edit_s=1 and curr_digit_s is 6 or 7: nothing blinks.
  - If edit_s=0 and done_s=1: all anodes are high for the whole phase.
  - If edit_s and done_s are both 1: edit rules apply and done is ignored.
  - When phase=ON: normal display.
- Output timing: an, seg and dp are registered and reflect the new index one clk after the slot tick. Exactly one an bit is low when not blanked, and an is never multi-hot.
- When rst_n rises mid-frame, the first frame displays zeros (shadow=0) until the first frame latch.

Test Plan (REFRESH_DIV=4, BLINK_DIV=64):
1. Hold rst_n=0 -> an=FF, seg=7F, dp=1. Release -> an cycles FE,FD,..,7F at 4-cycle slots, showing digit 0 (seg=40). Assert rst_n=0 mid-slot -> outputs return to FF/7F/1 in the same cycle, with no clock edge needed.
2. time_i=36'h123456789, edit=0, done=0, after one frame latch -> an[7..0] show 1,2,3,4,5,6,7,8; seg=79 at an[7]; seg=00 at an[0]; dp=0 only when an[6], an[4] or an[2] is low.
3. Change time_i to 36'h000000000 while index=3 -> remaining slots of that frame still show the old digits; zeros appear from index 0 of the next frame.
4. edit=1, curr_digit=2 -> an[5] never goes low during 64-cycle phase-OFF windows and shows m2 during phase-ON; other digits are unaffected. curr_digit=6 -> no digit blinks.
5. done=1, edit=0 -> an=FF for the entire 64-cycle OFF window and normal scanning in the ON window. Then done=1, edit=1, curr_digit=0 -> only an[7] blinks.
6. time_i nibble [19:16]=4'hA -> seg=3F (dash) at index 3; all other digits decode normally.
